// File: rtl/fetch_align.sv
// Fetch/realign stage: word fetches from IMEM into a 4-halfword buffer, emits aligned 16/32-bit instructions.
// Latency: redirect to first InstrValid_o is 2 cycles plus IMEM latency; outputs are combinational from registers.
// Backpressure: InstrReady_i low holds the head stable; fetching stops once more than 2 halfwords are buffered.
module fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        FetchReq_o,
    output logic [31:0] FetchAddr_o,
    input  logic [31:0] FetchData_i,
    input  logic        FetchValid_i,
    input  logic        Redirect_i,
    input  logic [31:0] RedirectPC_i,
    output logic [31:0] Instr_o,
    output logic [31:0] InstrPC_o,
    output logic        Compressed_o,
    output logic        InstrValid_o,
    input  logic        InstrReady_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_KILL = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_buf;
    logic [2:0]  r_count;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_head_pc;
    logic        r_drop_first;

    logic        w_has;
    logic        w_comp;
    logic        w_req;
    logic        w_xfer;
    logic        w_push;
    logic [1:0]  w_pop;
    logic [1:0]  w_push_n;
    logic [2:0]  w_base;
    logic [2:0]  w_count_nxt;
    logic [31:0] w_push_dat;
    logic [31:0] w_push_msk;
    logic [63:0] w_shift;
    logic [63:0] w_ins_dat;
    logic [63:0] w_ins_msk;
    logic [63:0] w_buf_nxt;
    logic        w_unused;

    // Halfword 0 of the buffer lives in r_buf[15:0]; outputs read as zero while the buffer is empty.
    assign w_has        = (r_count != 3'd0);
    assign w_comp       = w_has & (r_buf[1:0] != 2'b11);
    assign Compressed_o = w_comp;
    assign InstrValid_o = w_comp | (r_count >= 3'd2);
    assign Instr_o      = !w_has ? 32'h0 : (w_comp ? {16'h0, r_buf[15:0]} : r_buf[31:0]);
    assign InstrPC_o    = r_head_pc;
    assign FetchAddr_o  = r_fetch_pc;

    assign w_req      = rst_i & (r_state == ST_IDLE) & (r_count <= 3'd2) & ~Redirect_i;
    assign FetchReq_o = w_req;
    assign w_xfer     = InstrValid_o & InstrReady_i & ~Redirect_i;
    assign w_pop      = !w_xfer ? 2'd0 : (w_comp ? 2'd1 : 2'd2);
    assign w_push     = (r_state == ST_WAIT) & FetchValid_i & ~Redirect_i;
    assign w_push_n   = !w_push ? 2'd0 : (r_drop_first ? 2'd1 : 2'd2);

    // Redirect targets are halfword aligned, so the byte-offset bit carries no information.
    assign w_unused = RedirectPC_i[0];

    // Pop first, then land the returned halfwords directly behind whatever remains.
    always_comb begin
        w_shift     = r_buf >> {w_pop, 4'b0000};
        w_base      = r_count - {1'b0, w_pop};
        w_push_dat  = r_drop_first ? {16'h0, FetchData_i[31:16]} : FetchData_i;
        w_push_msk  = r_drop_first ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        w_ins_dat   = {32'h0, w_push_dat} << {w_base, 4'b0000};
        w_ins_msk   = {32'h0, w_push_msk} << {w_base, 4'b0000};
        w_buf_nxt   = w_push ? ((w_shift & ~w_ins_msk) | w_ins_dat) : w_shift;
        w_count_nxt = Redirect_i ? 3'd0 : (r_count - {1'b0, w_pop} + {1'b0, w_push_n});
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_req) w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (FetchValid_i)    w_state_nxt = ST_IDLE;
                else if (Redirect_i) w_state_nxt = ST_KILL;
            end
            ST_KILL: if (FetchValid_i) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= ST_IDLE;
            r_buf        <= '0;
            r_count      <= 3'd0;
            r_fetch_pc   <= RESET_PC;
            r_head_pc    <= RESET_PC;
            r_drop_first <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_buf   <= w_buf_nxt;
            r_count <= w_count_nxt;
            if (Redirect_i) begin
                r_head_pc    <= {RedirectPC_i[31:1], 1'b0};
                r_fetch_pc   <= {RedirectPC_i[31:2], 2'b00};
                r_drop_first <= RedirectPC_i[1];
            end else begin
                if (w_req)  r_fetch_pc   <= r_fetch_pc + 32'd4;
                if (w_xfer) r_head_pc    <= r_head_pc + (w_comp ? 32'd2 : 32'd4);
                if (w_push) r_drop_first <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_align.sv
// Scoreboard bench for fetch_align: an IMEM image drives both a randomly delayed responder and an
// instruction-stream model; a monitor compares every presented instruction against the expected stream.
module tb_fetch_align;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        FetchReq_o;
    logic [31:0] FetchAddr_o;
    logic [31:0] FetchData_i;
    logic        FetchValid_i;
    logic        Redirect_i;
    logic [31:0] RedirectPC_i;
    logic [31:0] Instr_o;
    logic [31:0] InstrPC_o;
    logic        Compressed_o;
    logic        InstrValid_o;
    logic        InstrReady_i;

    fetch_align #(.RESET_PC(RESET_PC)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .FetchReq_o   (FetchReq_o),
        .FetchAddr_o  (FetchAddr_o),
        .FetchData_i  (FetchData_i),
        .FetchValid_i (FetchValid_i),
        .Redirect_i   (Redirect_i),
        .RedirectPC_i (RedirectPC_i),
        .Instr_o      (Instr_o),
        .InstrPC_o    (InstrPC_o),
        .Compressed_o (Compressed_o),
        .InstrValid_o (InstrValid_o),
        .InstrReady_i (InstrReady_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        comp;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [0:1023];
    int          checks = 0;
    int          errors = 0;
    int          xfers = 0;
    logic [31:0] exp_fetch;
    bit          inject_stale = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] get_hw(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[11:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [15:0] rand_hw();
        logic [15:0] v;
        v = 16'($urandom);
        if ($urandom_range(0, 1) == 1) v[1:0] = 2'b11;
        else if (v[1:0] == 2'b11)      v[1:0] = 2'b01;
        return v;
    endfunction

    // Expected stream from a start address: compressed halfwords advance 2 bytes, others take the next halfword too.
    task automatic load_stream(input logic [31:0] start);
        logic [31:0] pc;
        logic [15:0] h0;
        exp_t        e;
        sb.delete();
        pc = start;
        for (int n = 0; n < 80; n++) begin
            h0   = get_hw(pc);
            e.pc = pc;
            if (h0[1:0] != 2'b11) begin
                e.instr = {16'h0, h0};
                e.comp  = 1'b1;
                pc      = pc + 32'd2;
            end else begin
                e.instr = {get_hw(pc + 32'd2), h0};
                e.comp  = 1'b0;
                pc      = pc + 32'd4;
            end
            sb.push_back(e);
        end
    endtask

    // IMEM responder: one request at a time, data 1..3 cycles after the request cycle.
    initial begin : responder
        bit          pend;
        logic [31:0] pend_addr;
        int          pend_wait;
        pend = 1'b0;
        pend_addr = '0;
        pend_wait = 0;
        FetchValid_i = 1'b0;
        FetchData_i  = '0;
        forever begin
            @(posedge clk_i);
            #2;
            FetchValid_i = 1'b0;
            if (!rst_i) begin
                pend = 1'b0;
            end else if (inject_stale) begin
                FetchValid_i = 1'b1;
                FetchData_i  = 32'hBAD0_BAD3;
                inject_stale = 1'b0;
            end else if (pend) begin
                if (pend_wait == 0) begin
                    FetchValid_i = 1'b1;
                    FetchData_i  = mem[pend_addr[11:2]];
                    pend = 1'b0;
                end else begin
                    pend_wait--;
                end
            end
            @(negedge clk_i);
            if (rst_i && FetchReq_o) begin
                checks++;
                if (pend) begin
                    errors++;
                    $display("FAIL one_outstanding: FetchReq_o=1 with a request pending, addr %h", FetchAddr_o);
                end
                chk("fetch_addr", FetchAddr_o, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
                pend      = 1'b1;
                pend_addr = FetchAddr_o;
                pend_wait = $urandom_range(0, 2);
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk_i);
            if (rst_i && !Redirect_i && InstrValid_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: InstrValid_o=1 at pc %h with nothing expected", InstrPC_o);
                end else begin
                    chk("instr", Instr_o, sb[0].instr);
                    chk("instr_pc", InstrPC_o, sb[0].pc);
                    chk("compressed", {31'h0, Compressed_o}, {31'h0, sb[0].comp});
                    if (InstrReady_i) begin
                        void'(sb.pop_front());
                        xfers++;
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, {31'h0, FetchReq_o}, 32'h0);
        chk({tag, "_valid"}, {31'h0, InstrValid_o}, 32'h0);
        chk({tag, "_instr"}, Instr_o, 32'h0);
        chk({tag, "_comp"}, {31'h0, Compressed_o}, 32'h0);
        chk({tag, "_faddr"}, FetchAddr_o, RESET_PC);
        chk({tag, "_ipc"}, InstrPC_o, RESET_PC);
    endtask

    task automatic check_first_req(input string tag);
        @(negedge clk_i);
        chk({tag, "_first_req"}, {31'h0, FetchReq_o}, 32'h1);
        chk({tag, "_first_addr"}, FetchAddr_o, RESET_PC);
        @(posedge clk_i);
        #1;
    endtask

    task automatic run(input int n, input int pct);
        for (int i = 0; i < n; i++) begin
            InstrReady_i = ($urandom_range(0, 99) < pct);
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic redirect(input logic [31:0] target);
        Redirect_i   = 1'b1;
        RedirectPC_i = target;
        exp_fetch    = {target[31:2], 2'b00};
        load_stream({target[31:1], 1'b0});
        @(posedge clk_i);
        #1;
        Redirect_i = 1'b0;
    endtask

    task automatic wait_req();
        bit seen;
        seen = 1'b0;
        InstrReady_i = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_i);
            seen = FetchReq_o;
            @(posedge clk_i);
            #1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_req: FetchReq_o=0 for 20 cycles, required 1");
        end
    endtask

    task automatic segment(input string tag, input logic [31:0] target, input int n, input int pct, input bit mid_wait);
        int x0;
        if (mid_wait) wait_req();
        redirect(target);
        x0 = xfers;
        run(n, pct);
        if (pct >= 50) begin
            checks++;
            if (xfers == x0) begin
                errors++;
                $display("FAIL %s_progress: transfers=0 in %0d cycles, required >0", tag, n);
            end
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int x0;
        for (int i = 0; i < 1024; i++) mem[i] = {rand_hw(), rand_hw()};
        mem[0]           = 32'h00A0_0093;
        mem[32'h200 >> 2] = 32'h4505_4501;
        mem[32'h300 >> 2] = 32'h0093_4501;
        mem[32'h304 >> 2] = 32'h0000_00A0;
        for (int i = 32'h400 >> 2; i < (32'h500 >> 2); i++) mem[i] = mem[i] | 32'h0003_0003;

        rst_i        = 1'b0;
        Redirect_i   = 1'b0;
        RedirectPC_i = '0;
        InstrReady_i = 1'b0;
        exp_fetch    = RESET_PC;
        load_stream(RESET_PC);
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("rst_init");
        rst_i        = 1'b1;
        InstrReady_i = 1'b1;
        check_first_req("boot");
        run(20, 100);

        segment("pair16", 32'h0000_0200, 20, 100, 1'b0);
        segment("straddle", 32'h0000_0300, 20, 100, 1'b0);
        segment("kill", 32'h0000_0106, 20, 100, 1'b1);
        segment("wrap", 32'hFFFF_FFFA, 30, 100, 1'b0);

        // Long stall on 32-bit code: buffer fills and fetching stops, then drains back to back.
        InstrReady_i = 1'b0;
        redirect(32'h0000_0400);
        run(14, 0);
        @(negedge clk_i);
        chk("stall_req", {31'h0, FetchReq_o}, 32'h0);
        chk("stall_valid", {31'h0, InstrValid_o}, 32'h1);
        @(posedge clk_i);
        #1;
        x0 = xfers;
        run(2, 100);
        chk("stall_release", xfers, x0 + 2);
        run(20, 100);

        for (int s = 0; s < 30; s++) begin
            segment("rand", $urandom_range(0, 4095), $urandom_range(20, 60),
                    $urandom_range(30, 100), (s % 3) == 0);
        end

        // Reset while a fetch is outstanding; the late response must be ignored.
        wait_req();
        rst_i = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        exp_fetch    = RESET_PC;
        load_stream(RESET_PC);
        inject_stale = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        check_first_req("rst_mid");
        x0 = xfers;
        run(40, 80);
        checks++;
        if (xfers == x0) begin
            errors++;
            $display("FAIL rst_mid_progress: transfers=0 after reset, required >0");
        end

        checks++;
        if (xfers < 100) begin
            errors++;
            $display("FAIL xfer_total: got %0d transfers, required >=100", xfers);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
